gol_gen_scheduler: RTL

Generation scheduler for the Game of Life core. Decides when a new generation is computed (free-running period or single-step), sweeps every cell address to the cell-update engine over a valid/ready handshake, waits for the engine to drain, then issues a one-cycle buffer-swap pulse, aligned to vertical blanking, so the VGA scan-out never shows a half-updated board. Sits between the user controls / VGA timing and the next-state engine plus its double-buffered board RAM.

---
 rtl/gol_gen_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gol_gen_scheduler.sv
// Game of Life generation scheduler: period/step trigger, row-major cell sweep,
// engine drain and a vblank-aligned buffer swap (GOL_VBLANK_SYNC_EN enables the vblank wait).
module gol_gen_scheduler #(
    parameter int COLS     = 64,
    parameter int ROWS     = 48,
    parameter int PERIOD_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      step,
    input  logic [PERIOD_W-1:0]       period,
    input  logic                      vblank,
    input  logic                      cell_ready,
    input  logic                      eng_busy,
    output logic                      cell_valid,
    output logic [$clog2(ROWS)-1:0]   cell_row,
    output logic [$clog2(COLS)-1:0]   cell_col,
    output logic                      buf_swap,
    output logic [15:0]               gen_count,
    output logic                      busy,
    output logic                      overrun
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

`ifdef GOL_VBLANK_SYNC_EN
    localparam bit VBLANK_SYNC = 1'b1;
`else
    localparam bit VBLANK_SYNC = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, SWAP_WAIT, SWAP} state_t;

    state_t              state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] period_m1;
    logic                pending;
    logic                tick;
    logic                sweep_start;
    logic                step_ok;
    logic                swap_go;

    always_comb begin
        period_m1   = (period == '0) ? '0 : period - 1'b1;
        // >= rather than == so a period shortened mid-count still ticks promptly
        tick        = run && (timer >= period_m1);
        sweep_start = (state == IDLE) && pending;
        step_ok     = step && !run && (state == IDLE) && !pending;
        swap_go     = !VBLANK_SYNC || vblank;
    end

    // NOTE: every register below is assigned with <= so all of them sample
    // the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            pending    <= 1'b0;
            cell_valid <= 1'b0;
            cell_row   <= '0;
            cell_col   <= '0;
            buf_swap   <= 1'b0;
            gen_count  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            buf_swap <= 1'b0;
            timer    <= (!run || tick) ? '0 : timer + 1'b1;
            // A tick landing on the cycle the pending request is consumed is a new request, not an overrun
            overrun  <= tick && pending && !sweep_start;

            if (tick || step_ok)
                pending <= 1'b1;
            else if (sweep_start)
                pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (pending) begin
                        state      <= SWEEP;
                        cell_valid <= 1'b1;
                        busy       <= 1'b1;
                        cell_row   <= '0;
                        cell_col   <= '0;
                    end
                end
                SWEEP: begin
                    if (cell_ready) begin
                        if (cell_col == COL_LAST) begin
                            cell_col <= '0;
                            if (cell_row == ROW_LAST) begin
                                state      <= DRAIN;
                                cell_valid <= 1'b0;
                                cell_row   <= '0;
                            end else begin
                                cell_row <= cell_row + 1'b1;
                            end
                        end else begin
                            cell_col <= cell_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!eng_busy)
                        state <= SWAP_WAIT;
                end
                SWAP_WAIT: begin
                    if (swap_go) begin
                        state     <= SWAP;
                        buf_swap  <= 1'b1;
                        gen_count <= gen_count + 1'b1;
                    end
                end
                SWAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cell_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
